oam_dma: RTL and testbench
==========================

# oam_dma

Sprite-DMA engine for the NES PPU path, sitting directly upstream of the PPU register interface on the CPU memory bus. A CPU write to the trigger register ($4014) halts the CPU and copies one 256-byte CPU page into sprite RAM through 256 successive writes to the OAM data register ($2004). The top level muxes the bus outputs of this block over the CPU's outputs whenever `active_out` is high.

## Interface
Parameters:
- `TRIG_ADDR`, 16'h4014: CPU address whose write starts a transfer.
- `OAM_DATA_ADDR`, 16'h2004: destination address written once per byte.

Ports:
- `clk_in` input 1: 100MHz system clock. The block uses one clock; all state changes on its rising edge.
- `rst_in` input 1: reset, synchronous and active-high.
- `cpumc_a_in` input 16: CPU-driven address bus.
- `cpumc_din_in` input 8: CPU-driven write data. On a trigger write this is the source page number.
- `cpu_r_nw_in` input 1: CPU read/not-write.
- `cpumc_dout_in` input 8: memory read data returned for `cpumc_a_out`.
- `active_out` output 1: DMA owns the bus. The top level holds the CPU RDY low while this is high.
- `cpumc_a_out` output 16: DMA address.
- `cpumc_d_out` output 8: DMA write data.
- `cpumc_r_nw_out` output 1: DMA read/not-write.

## Operation
- Reset values:
  - outputs: `active_out`=0, `cpumc_a_out`=0, `cpumc_d_out`=0, `cpumc_r_nw_out`=1.
  - internal: state=IDLE, byte counter=0, page=0, trigger-history flag=1.
- Trigger condition: `cpu_r_nw_in`=0 and `cpumc_a_in`==`TRIG_ADDR`.
  - Rising-edge detected: a transfer starts only when the condition is true now and the history flag (the condition in the previous cycle) is 0.
  - The history flag updates every cycle.
  - Because the flag resets to 1, a condition held through reset does not trigger.
- On a trigger in IDLE: page <= `cpumc_din_in`, counter <= 0, next state START.
- FSM states:
  - IDLE: `active_out`=0, `cpumc_r_nw_out`=1, `cpumc_a_out`/`cpumc_d_out` hold their last values. Leaves only on a trigger.
  - START: single alignment cycle. `active_out`=1, `cpumc_r_nw_out`=1, `cpumc_a_out`=0. Always goes to READ.
  - READ: `cpumc_a_out`={page, counter}, `cpumc_r_nw_out`=1. `cpumc_d_out` is loaded from `cpumc_dout_in` at the end of this cycle. Goes to WRITE.
  - WRITE: `cpumc_a_out`=`OAM_DATA_ADDR`, `cpumc_r_nw_out`=0, `cpumc_d_out`=the latched byte.
    - If counter==255, go to IDLE.
    - Otherwise counter += 1 and go to READ.
- Arithmetic and boundaries:
  - The counter is 8 bits. The source address is the concatenation of page and counter, never a sum, so page 8'hFF reads $FF00–$FFFF with no carry.
- `active_out` is high in every START/READ/WRITE cycle and is registered.
- Trigger writes arriving while not IDLE are ignored and not queued. The history flag still tracks them.
- Reset mid-transfer: next cycle is IDLE, `active_out`=0, no further bus writes. A partial OAM update is acceptable.
- Memory contract: `cpumc_dout_in` must be valid by the end of the READ cycle in which its address is presented.

## Timing
- Cycle T: trigger condition first seen true; page sampled.
- T+1: START, `active_out` rises.
- T+2+2k: READ of byte k, for k=0..255.
- T+3+2k: WRITE of byte k to `OAM_DATA_ADDR`.
- T+514: IDLE, `active_out`=0.
- Total `active_out` high time is 513 cycles.
- Exactly 256 cycles have `cpumc_r_nw_out`=0, and all of them address `OAM_DATA_ADDR`.
- Back-to-back transfers:
  - The earliest new trigger is sampled at T+514, provided the condition was low at T+513.
  - A trigger level held continuously from T onward never restarts.

## Test plan
- Page 8'h02, memory[$0200+i]=i^8'hA5 → 256 writes to $2004 with data i^8'hA5 in order. `active_out` high T+1..T+513, low at T+514.
- Page 8'hFF → first read address $FF00, last $FFFF. No address $0000 appears after $FFFF.
- Trigger held for 10 consecutive cycles → exactly one transfer. A second pulse during the transfer at T+100 causes nothing. A fresh pulse at T+600 starts a second full transfer.
- `rst_in` asserted at T+200 for 1 cycle → at T+201 `active_out`=0 and `cpumc_r_nw_out`=1. Bus writes total 99, byte indices 0..98. No writes thereafter.
- Write to $4015 or a read of $4014 → no activity, `active_out` stays 0.
- Reset with the trigger condition held high through release → no transfer until the condition drops and rises again.

Source files
------------

// File: rtl/oam_dma.sv
// Sprite-DMA engine: a rising-edge write to TRIG_ADDR copies one 256-byte CPU page
// into OAM via alternating READ/WRITE bus cycles, with all bus outputs registered.
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR     = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] cpumc_a_in,
  input  logic [7:0]  cpumc_din_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpumc_dout_in,
  output logic        active_out,
  output logic [15:0] cpumc_a_out,
  output logic [7:0]  cpumc_d_out,
  output logic        cpumc_r_nw_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hist_q;
  logic        trig_cond;
  logic        trig;

  logic        active_q, active_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  d_q, d_d;
  logic        rnw_q, rnw_d;

  assign trig_cond = !cpu_r_nw_in && (cpumc_a_in == TRIG_ADDR);
  assign trig      = trig_cond && !hist_q;

  // Outputs are registered from the next state, so each bus phase appears
  // in the same cycle as the state it belongs to.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      page_q   <= '0;
      cnt_q    <= '0;
      hist_q   <= 1'b1;
      active_q <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
      rnw_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      cnt_q    <= cnt_d;
      hist_q   <= trig_cond;
      active_q <= active_d;
      a_q      <= a_d;
      d_q      <= d_d;
      rnw_q    <= rnw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          page_d  = cpumc_din_in;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: state_d = S_READ;
      S_READ:  state_d = S_WRITE;
      S_WRITE: begin
        if (cnt_q == 8'hFF) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    active_d = (state_d != S_IDLE);
    rnw_d    = (state_d != S_WRITE);
    a_d      = a_q;
    d_d      = d_q;
    unique case (state_d)
      S_START: a_d = '0;
      S_READ:  a_d = {page_d, cnt_d};
      S_WRITE: begin
        a_d = OAM_DATA_ADDR;
        d_d = cpumc_dout_in;
      end
      default: ;
    endcase
  end

  assign active_out     = active_q;
  assign cpumc_a_out    = a_q;
  assign cpumc_d_out    = d_q;
  assign cpumc_r_nw_out = rnw_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: table of bus operations, each checked cycle-by-cycle against
// the documented transfer timeline over a randomly filled memory.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_in;
  logic [7:0]  din;
  logic        rnw_in;
  logic [7:0]  dout;
  logic        active;
  logic [15:0] a_out;
  logic [7:0]  d_out;
  logic        rnw_out;

  logic [7:0]  mem [65536];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dout = mem[a_out];

  oam_dma #(
    .TRIG_ADDR    (16'h4014),
    .OAM_DATA_ADDR(16'h2004)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .cpumc_a_in    (a_in),
    .cpumc_din_in  (din),
    .cpu_r_nw_in   (rnw_in),
    .cpumc_dout_in (dout),
    .active_out    (active),
    .cpumc_a_out   (a_out),
    .cpumc_d_out   (d_out),
    .cpumc_r_nw_out(rnw_out)
  );

  typedef struct {
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  data;
    int          hold;
    int          pulse_at;
    int          rst_at;
    bit          chain;
    logic [7:0]  next_page;
    bit          expect_start;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    rnw_in = 1'b1;
    a_in   = 16'h8000;
    din    = 8'($urandom);
  endtask

  task automatic bus_op(input logic r, input logic [15:0] a, input logic [7:0] d);
    rnw_in = r;
    a_in   = a;
    din    = d;
  endtask

  // Called in the cycle after the trigger was driven (cycle T); n counts cycles from T.
  task automatic run_transfer(input logic [7:0] page, input int hold, input int pulse_at,
                              input int rst_at, input bit chain, input logic [7:0] next_page);
    int writes;
    int last;
    int k;
    logic        e_act, e_rnw;
    logic [15:0] e_a;
    logic [7:0]  e_d;
    bit          chk_d;
    writes = 0;
    last   = chain ? 514 : 520;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      chk_d = 1'b1;
      if (rst_at > 0 && n > rst_at) begin
        e_act = 1'b0; e_rnw = 1'b1; e_a = 16'h0000; e_d = 8'h00;
      end else if (n == 1) begin
        e_act = 1'b1; e_rnw = 1'b1; e_a = 16'h0000; e_d = 8'h00; chk_d = 1'b0;
      end else if (n <= 513 && n % 2 == 0) begin
        k = (n - 2) / 2;
        e_act = 1'b1; e_rnw = 1'b1; e_a = {page, 8'(k)}; e_d = 8'h00; chk_d = (n > 2);
        if (n > 2) e_d = mem[{page, 8'(k - 1)}];
      end else if (n <= 513) begin
        k = (n - 3) / 2;
        e_act = 1'b1; e_rnw = 1'b0; e_a = 16'h2004; e_d = mem[{page, 8'(k)}];
      end else begin
        e_act = 1'b0; e_rnw = 1'b1; e_a = 16'h2004; e_d = mem[{page, 8'hFF}];
      end
      chk($sformatf("active n=%0d", n), active, e_act);
      chk($sformatf("r_nw n=%0d", n), rnw_out, e_rnw);
      chk($sformatf("addr n=%0d", n), a_out, e_a);
      if (chk_d) chk($sformatf("data n=%0d", n), d_out, e_d);
      if (rnw_out === 1'b0) writes++;
      rst = (n == rst_at);
      if (n < hold) bus_op(1'b0, 16'h4014, page);
      else if (n == pulse_at) bus_op(1'b0, 16'h4014, ~page);
      else if (chain && n == last) bus_op(1'b0, 16'h4014, next_page);
      else bus_idle();
    end
    chk($sformatf("write_count page=%0h", page), writes, (rst_at > 0) ? (rst_at - 1) / 2 : 256);
  endtask

  initial begin
    bit pre;
    vec_t v;
    rst = 1'b1;
    bus_idle();
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

    repeat (3) @(negedge clk);
    chk("reset active", active, 1'b0);
    chk("reset addr", a_out, 16'h0000);
    chk("reset data", d_out, 8'h00);
    chk("reset r_nw", rnw_out, 1'b1);
    rst = 1'b0;

    vecs[0]  = '{1'b0, 16'h4014, 8'h02, 1, 0, 0, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 16'h4015, 8'h03, 1, 0, 0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 16'h4014, 8'h04, 1, 0, 0, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 16'h4014, 8'hFF, 1, 0, 0, 1'b1, 8'h37, 1'b1};
    vecs[4]  = '{1'b0, 16'h4014, 8'h37, 1, 0, 0, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 16'h4014, 8'h5A, 10, 100, 0, 1'b0, 8'h00, 1'b1};
    vecs[6]  = '{1'b0, 16'h4014, 8'hC3, 1, 0, 200, 1'b0, 8'h00, 1'b1};
    vecs[7]  = '{1'b0, 16'h2004, 8'h11, 1, 0, 0, 1'b0, 8'h00, 1'b0};
    for (int i = 8; i < 11; i++)
      vecs[i] = '{1'b0, 16'h4014, 8'($urandom), 1, 0, 0, 1'b0, 8'h00, 1'b1};
    vecs[11] = '{1'b0, 16'($urandom_range(16'h0000, 16'h4013)), 8'h22, 1, 0, 0, 1'b0, 8'h00, 1'b0};

    pre = 1'b0;
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      if (!pre) begin
        repeat (3) @(negedge clk) bus_idle();
        @(negedge clk);
        bus_op(v.rnw, v.addr, v.data);
      end
      if (v.expect_start) begin
        run_transfer(v.data, v.hold, v.pulse_at, v.rst_at, v.chain, v.next_page);
      end else begin
        for (int n = 1; n <= 4; n++) begin
          @(negedge clk);
          chk($sformatf("no_start vec=%0d n=%0d active", i, n), active, 1'b0);
          chk($sformatf("no_start vec=%0d n=%0d r_nw", i, n), rnw_out, 1'b1);
          bus_idle();
        end
      end
      pre = v.chain;
    end

    // Trigger level held through reset must not start a transfer.
    @(negedge clk);
    rst = 1'b1;
    bus_op(1'b0, 16'h4014, 8'h11);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      chk($sformatf("held_through_reset n=%0d", n), active, 1'b0);
    end
    repeat (2) @(negedge clk) bus_idle();
    @(negedge clk);
    bus_op(1'b0, 16'h4014, 8'h11);
    run_transfer(8'h11, 1, 0, 0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
